// File: rtl/sram_write_buffer.sv
// Posted-write FIFO between the CPU sram write port and the bridge write channel.
// Optional store merging into the youngest entry is enabled with WBUF_MERGE_EN.
module sram_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_size,
    input  logic [3:0]  cpu_wstrb,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic        wr_req,
    output logic        wr_wr,
    output logic [1:0]  wr_size,
    output logic [3:0]  wr_wstrb,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_wdata,
    input  logic        wr_addr_ok,
    input  logic        wr_data_ok,
    input  logic        rd_check,
    input  logic [31:0] rd_addr,
    output logic        rd_hazard,
    output logic        buf_empty
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [PTR_W:0] FULL_X = {1'b1, {PTR_W{1'b0}}};

    state_t         state_q;
    logic [31:0]    addr_q [DEPTH];
    logic [31:0]    data_q [DEPTH];
    logic [3:0]     strb_q [DEPTH];
    logic [1:0]     size_q [DEPTH];
    logic [PTR_W:0] wptr_q, rptr_q, wptr_d, rptr_d, count;
    logic [PTR_W-1:0] widx, ridx, off;
    logic full, empty, accept, alloc, pop;
    logic data_ok_q, wr_req_q, hit;
    logic [1:0] rd_unused;

    assign widx  = wptr_q[PTR_W-1:0];
    assign ridx  = rptr_q[PTR_W-1:0];
    assign count = wptr_q - rptr_q;
    assign full  = (wptr_q ^ rptr_q) == FULL_X;
    assign empty = wptr_q == rptr_q;

`ifdef WBUF_MERGE_EN
    localparam logic [PTR_W-1:0] ONE = 1;
    logic [PTR_W-1:0] yidx;
    logic merge;
    assign yidx  = widx - ONE;
    // the head is frozen once it is offered downstream
    assign merge = cpu_req & cpu_wr & ~empty
                 & (addr_q[yidx][31:2] == cpu_addr[31:2])
                 & ~((yidx == ridx) & (state_q != IDLE));
    assign accept = cpu_req & cpu_wr & (~full | merge);
    assign alloc  = accept & ~merge;
`else
    assign accept = cpu_req & cpu_wr & ~full;
    assign alloc  = accept;
`endif

    assign pop    = (state_q == WAIT) & wr_data_ok;
    assign wptr_d = wptr_q + {{PTR_W{1'b0}}, alloc};
    assign rptr_d = rptr_q + {{PTR_W{1'b0}}, pop};

    assign cpu_addr_ok = accept;
    assign cpu_data_ok = data_ok_q;
    assign wr_req      = wr_req_q;
    assign wr_wr       = 1'b1;
    assign wr_size     = size_q[ridx];
    assign wr_wstrb    = strb_q[ridx];
    assign wr_addr     = addr_q[ridx];
    assign wr_wdata    = data_q[ridx];
    assign buf_empty   = empty & (state_q == IDLE);
    assign rd_hazard   = rd_check & hit;
    assign rd_unused   = rd_addr[1:0];

    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - ridx;
            if (({1'b0, off} < count) &&
                (addr_q[i][31:2] == rd_addr[31:2]))
                hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                strb_q[i] <= '0;
                size_q[i] <= '0;
            end
            wptr_q    <= '0;
            rptr_q    <= '0;
            state_q   <= IDLE;
            wr_req_q  <= 1'b0;
            data_ok_q <= 1'b0;
        end else begin
            data_ok_q <= accept;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            if (alloc) begin
                addr_q[widx] <= cpu_addr;
                data_q[widx] <= cpu_wdata;
                strb_q[widx] <= cpu_wstrb;
                size_q[widx] <= cpu_size;
            end
`ifdef WBUF_MERGE_EN
            if (merge) begin
                for (int b = 0; b < 4; b++)
                    if (cpu_wstrb[b])
                        data_q[yidx][8*b +: 8] <= cpu_wdata[8*b +: 8];
                strb_q[yidx]       <= strb_q[yidx] | cpu_wstrb;
                size_q[yidx]       <= 2'b10;
                addr_q[yidx][1:0]  <= 2'b00;
            end
`endif
            unique case (state_q)
                IDLE: if (!empty) begin
                    state_q  <= REQ;
                    wr_req_q <= 1'b1;
                end
                REQ: if (wr_addr_ok) begin
                    state_q  <= WAIT;
                    wr_req_q <= 1'b0;
                end
                WAIT: if (wr_data_ok) begin
                    if (wptr_d != rptr_d) begin
                        state_q  <= REQ;
                        wr_req_q <= 1'b1;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    wr_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
